// File: rtl/versat_ctrl_pkg.sv
// Shared control-path constants and helpers for the Versat dispatch logic.
// Pure declarations: no latency, no flow control.
// Imported by the decoder and its one-hot decode helper.
package versat_ctrl_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // Index width for n targets, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Binary index to one-hot vector with an in-range flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the index.
module onehot_decode
    import versat_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot,
    output logic             in_range
);

    generate
        if (WIDTH == 1) begin : g_single
            // A single target is always selected, whatever the index says.
            logic unused_index;
            assign unused_index = ^index;
            assign onehot       = 1'b1;
            assign in_range     = 1'b1;
        end else begin : g_multi
            always_comb begin
                onehot   = '0;
                in_range = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (index == IDX_W'(i)) begin
                        onehot[i] = 1'b1;
                        in_range  = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/onehot_dispatch_decoder.sv
// Accepts an encoded index and holds a registered one-hot grant until acked or timed out.
// Latency: one cycle from transfer to grant; a combinational ack allows one grant per cycle.
// Backpressure: in_ready drops while a grant is outstanding and not acknowledged this cycle.
module onehot_dispatch_decoder
    import versat_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int IDX_W   = idx_width(WIDTH),
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_valid,
    input  logic [WIDTH-1:0] out_ack,
    output logic             err_range,
    output logic             err_timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic             state, state_nxt;
    logic [WIDTH-1:0] onehot_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_range_nxt, err_timeout_nxt;
    logic [WIDTH-1:0] dec_onehot;
    logic             dec_in_range;
    logic             ack_hit;
    logic             xfer;

    onehot_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .index    (in_index),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // out_onehot is zero outside GRANT, so the ack mask alone qualifies the hit.
    assign ack_hit = |(out_ack & out_onehot);
    assign xfer    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_onehot  <= '0;
            cnt         <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_onehot  <= onehot_nxt;
            cnt         <= cnt_nxt;
            err_range   <= err_range_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        onehot_nxt      = out_onehot;
        cnt_nxt         = cnt;
        err_range_nxt   = 1'b0;
        err_timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (dec_in_range) begin
                        onehot_nxt = dec_onehot;
                        state_nxt  = ST_GRANT;
                        cnt_nxt    = '0;
                    end else begin
                        err_range_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (ack_hit) begin
                    cnt_nxt = '0;
                    if (xfer && dec_in_range) begin
                        onehot_nxt = dec_onehot;
                    end else begin
                        onehot_nxt    = '0;
                        state_nxt     = ST_IDLE;
                        err_range_nxt = xfer;
                    end
                end else if (TIMEOUT > 0) begin
                    // Ack has priority above, so a timeout only fires on an unacked cycle.
                    if (cnt == CNT_LAST) begin
                        onehot_nxt      = '0;
                        state_nxt       = ST_IDLE;
                        cnt_nxt         = '0;
                        err_timeout_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy      = (state == ST_GRANT);
        in_ready  = (state == ST_IDLE) | ((state == ST_GRANT) & ack_hit);
        out_valid = |out_onehot;
    end

endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// Directed bench: a WIDTH=4 no-timeout instance and a WIDTH=5 TIMEOUT=3 instance.
module tb_onehot_dispatch_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] a_index;
    logic       a_valid, a_ready, a_ovalid, a_erng, a_eto, a_busy;
    logic [3:0] a_onehot, a_ack;

    logic [2:0] b_index;
    logic       b_valid, b_ready, b_ovalid, b_erng, b_eto, b_busy;
    logic [4:0] b_onehot, b_ack;

    int passed = 0;
    int total  = 0;

    onehot_dispatch_decoder #(.WIDTH(4), .TIMEOUT(0)) u_a (
        .clk         (clk),
        .rst         (rst),
        .in_index    (a_index),
        .in_valid    (a_valid),
        .in_ready    (a_ready),
        .out_onehot  (a_onehot),
        .out_valid   (a_ovalid),
        .out_ack     (a_ack),
        .err_range   (a_erng),
        .err_timeout (a_eto),
        .busy        (a_busy)
    );

    onehot_dispatch_decoder #(.WIDTH(5), .TIMEOUT(3)) u_b (
        .clk         (clk),
        .rst         (rst),
        .in_index    (b_index),
        .in_valid    (b_valid),
        .in_ready    (b_ready),
        .out_onehot  (b_onehot),
        .out_valid   (b_ovalid),
        .out_ack     (b_ack),
        .err_range   (b_erng),
        .err_timeout (b_eto),
        .busy        (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_index = '0; a_valid = 1'b0; a_ack = '0;
        b_index = '0; b_valid = 1'b0; b_ack = '0;
        tick();
        tick();

        // Reset state
        chk("rst_a_onehot", a_onehot, 0);
        chk("rst_a_ovalid", a_ovalid, 0);
        chk("rst_a_busy",   a_busy,   0);
        chk("rst_a_erng",   a_erng,   0);
        chk("rst_a_eto",    a_eto,    0);
        chk("rst_b_onehot", b_onehot, 0);
        chk("rst_b_eto",    b_eto,    0);
        rst = 1'b0;
        #1;
        chk("rst_a_ready", a_ready, 1);

        // Basic decode of index 2, then ack
        a_index = 2'd2; a_valid = 1'b1;
        #1 chk("dec_ready_idle", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("dec_onehot", a_onehot, 4'b0100);
        chk("dec_busy",   a_busy,   1);
        chk("dec_ovalid", a_ovalid, 1);
        #1 chk("dec_ready_held", a_ready, 0);
        a_ack = 4'b0100;
        #1 chk("dec_ready_ack", a_ready, 1);
        tick();
        a_ack = '0;
        chk("dec_cleared", a_onehot, 0);
        chk("dec_idle",    a_busy,   0);

        // Back-to-back stream 0,3,1 with all acks held high
        a_ack = 4'hF; a_valid = 1'b1; a_index = 2'd0;
        #1 chk("b2b_ready0", a_ready, 1);
        tick();
        chk("b2b_oh0", a_onehot, 4'b0001);
        a_index = 2'd3;
        #1 chk("b2b_ready1", a_ready, 1);
        tick();
        chk("b2b_oh1", a_onehot, 4'b1000);
        a_index = 2'd1;
        #1 chk("b2b_ready2", a_ready, 1);
        tick();
        chk("b2b_oh2", a_onehot, 4'b0010);
        a_valid = 1'b0;
        #1 chk("b2b_ready3", a_ready, 1);
        tick();
        chk("b2b_done", a_onehot, 0);
        chk("b2b_busy", a_busy,   0);
        a_ack = '0;

        // Spurious acks on non-selected lines
        a_index = 2'd0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_ack = 4'b1110;
        #1 chk("spur_ready", a_ready, 0);
        tick();
        chk("spur_held", a_onehot, 4'b0001);
        chk("spur_busy", a_busy,   1);
        a_index = 2'd2; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("spur_no_xfer", a_onehot, 4'b0001);

        // Ack plus new index replaces the grant in one edge
        a_ack = 4'b0001; a_index = 2'd3; a_valid = 1'b1;
        tick();
        a_ack = '0; a_valid = 1'b0;
        chk("replace_oh",   a_onehot, 4'b1000);
        chk("replace_busy", a_busy,   1);

        // Reset mid-grant while the active line acks
        rst = 1'b1; a_ack = 4'b1000;
        tick();
        chk("mrst_onehot", a_onehot, 0);
        chk("mrst_ovalid", a_ovalid, 0);
        chk("mrst_busy",   a_busy,   0);
        chk("mrst_erng",   a_erng,   0);
        chk("mrst_eto",    a_eto,    0);
        rst = 1'b0; a_ack = '0;
        #1 chk("mrst_ready", a_ready, 1);
        tick();
        chk("mrst_still_idle", a_onehot, 0);
        chk("mrst_no_err",     a_erng,   0);

        // Range error on WIDTH=5
        b_index = 3'd6; b_valid = 1'b1;
        #1 chk("rng_ready_pre", b_ready, 1);
        tick();
        b_valid = 1'b0;
        chk("rng_pulse",  b_erng,   1);
        chk("rng_onehot", b_onehot, 0);
        chk("rng_busy",   b_busy,   0);
        #1 chk("rng_ready_post", b_ready, 1);
        tick();
        chk("rng_pulse_end", b_erng, 0);

        // Highest in-range index on WIDTH=5
        b_index = 3'd4; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("top_idx_oh", b_onehot, 5'b10000);
        chk("top_idx_no_err", b_erng, 0);
        // Ack together with an out-of-range index: grant dropped, range pulse
        b_ack = 5'b10000; b_index = 3'd7; b_valid = 1'b1;
        tick();
        b_ack = '0; b_valid = 1'b0;
        chk("ackrng_oh",   b_onehot, 0);
        chk("ackrng_erng", b_erng,   1);
        chk("ackrng_busy", b_busy,   0);
        chk("ackrng_eto",  b_eto,    0);
        tick();
        chk("ackrng_end", b_erng, 0);

        // Timeout: grant held three cycles, then dropped with a pulse
        b_index = 3'd1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("to_c0", b_onehot, 5'b00010);
        tick();
        chk("to_c1", b_onehot, 5'b00010);
        tick();
        chk("to_c2",     b_onehot, 5'b00010);
        chk("to_c2_eto", b_eto,    0);
        tick();
        chk("to_drop",  b_onehot, 0);
        chk("to_pulse", b_eto,    1);
        chk("to_idle",  b_busy,   0);
        tick();
        chk("to_pulse_end", b_eto, 0);

        // Ack on the final cycle wins over the timeout
        b_index = 3'd1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        tick();
        chk("toack_c2", b_onehot, 5'b00010);
        b_ack = 5'b00010;
        tick();
        b_ack = '0;
        chk("toack_oh",  b_onehot, 0);
        chk("toack_eto", b_eto,    0);
        tick();
        chk("toack_eto_late", b_eto, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
